// File: rtl/full_st_add_pipe_pkg.sv
// Shared types and constants for the pipelined floating-point adder.
package full_st_add_pipe_pkg;

   localparam int unsigned EXP_W_DEF     = 8;
   localparam int unsigned MAN_W_DEF     = 23;
   localparam int unsigned FLUSH_EXP_DEF = 10;

   localparam int unsigned FLAG_INEXACT = 0;
   localparam int unsigned FLAG_FLUSH   = 1;
   localparam int unsigned FLAG_OVF     = 2;

   typedef struct packed {
      logic                 sgn;
      logic [EXP_W_DEF-1:0] exp;
      logic [MAN_W_DEF-1:0] man;
   } float_t;

endpackage

// File: rtl/full_st_add_pipe_lzc.sv
// Leading-zero count over a W-bit vector; returns W for an all-zero input.
module float_lzc #(
   parameter int unsigned W  = 28,
   parameter int unsigned CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  in_vec,
   output logic [CW-1:0] count
);

   // Ascending scan: the highest set bit is the last to overwrite the count.
   always_comb begin
      count = CW'(W);
      for (int unsigned i = 0; i < W; i++) begin
         if (in_vec[i]) count = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/full_st_add_pipe.sv
// Three-stage floating-point add/subtract (align, add, normalise/round) with
// a single shared stall enable driven by the output handshake.
module full_st_add_pipe
   import full_st_add_pipe_pkg::*;
#(
   parameter int unsigned EXP_W     = EXP_W_DEF,
   parameter int unsigned MAN_W     = MAN_W_DEF,
   parameter int unsigned FLUSH_EXP = FLUSH_EXP_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sub,
   input  logic [EXP_W+MAN_W:0] in_a,
   input  logic [EXP_W+MAN_W:0] in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [EXP_W+MAN_W:0] out_res,
   output logic [2:0]         out_flags
);

   localparam int unsigned FW  = MAN_W + 4;   // {hidden, man, guard, round, sticky}
   localparam int unsigned SW  = MAN_W + 5;   // magnitude incl. carry-out bit
   localparam int unsigned DW  = EXP_W + 1;
   localparam int unsigned MW1 = MAN_W + 1;
   localparam int unsigned PW  = EXP_W + MAN_W;
   localparam int unsigned CW  = $clog2(SW + 1);
   localparam int unsigned EW  = EXP_W + $clog2(SW) + 2;

   localparam logic signed [EW-1:0] E_ONE   = EW'(1);
   localparam logic signed [EW-1:0] E_ZERO  = EW'(0);
   localparam logic signed [EW-1:0] E_OVF   = EW'(2**EXP_W - 1);
   localparam logic signed [EW-1:0] E_FLUSH = EW'(FLUSH_EXP);

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   logic             a_sgn, b_sgn, swap, sticky, big_sgn, small_sgn;
   logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp;
   logic [MAN_W:0]   a_sig, b_sig, big_sig, small_sig;
   logic [DW-1:0]    diff;
   logic [FW-1:0]    small_ext, small_f;

   always_comb begin
      a_sgn     = in_a[EXP_W+MAN_W];
      b_sgn     = in_b[EXP_W+MAN_W] ^ in_sub;
      a_exp     = in_a[EXP_W+MAN_W-1:MAN_W];
      b_exp     = in_b[EXP_W+MAN_W-1:MAN_W];
      a_sig     = (a_exp == '0) ? '0 : {1'b1, in_a[MAN_W-1:0]};
      b_sig     = (b_exp == '0) ? '0 : {1'b1, in_b[MAN_W-1:0]};
      swap      = b_exp > a_exp;
      big_sgn   = swap ? b_sgn : a_sgn;
      small_sgn = swap ? a_sgn : b_sgn;
      big_exp   = swap ? b_exp : a_exp;
      small_exp = swap ? a_exp : b_exp;
      big_sig   = swap ? b_sig : a_sig;
      small_sig = swap ? a_sig : b_sig;
      diff      = {1'b0, big_exp} - {1'b0, small_exp};
      small_ext = {small_sig, 3'b000};
      sticky    = 1'b0;
      small_f   = '0;
      if (diff >= DW'(MAN_W + 3)) begin
         small_f[0] = |small_sig;
      end else begin
         for (int unsigned i = 0; i < FW; i++) begin
            if (i < 32'(diff)) sticky = sticky | small_ext[i];
         end
         small_f = (small_ext >> diff) | FW'(sticky);
      end
   end

   logic             s1_valid, s1_big_sgn, s1_small_sgn;
   logic [EXP_W-1:0] s1_exp;
   logic [FW-1:0]    s1_big, s1_small;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid     <= 1'b0;
         s1_big_sgn   <= 1'b0;
         s1_small_sgn <= 1'b0;
         s1_exp       <= '0;
         s1_big       <= '0;
         s1_small     <= '0;
      end else if (adv) begin
         s1_valid     <= in_valid;
         s1_big_sgn   <= big_sgn;
         s1_small_sgn <= small_sgn;
         s1_exp       <= big_exp;
         s1_big       <= {big_sig, 3'b000};
         s1_small     <= small_f;
      end
   end

   // One extra bit over the magnitude width so same-sign carry-out cannot wrap.
   logic [SW:0]   va, vb, sum;
   logic [SW-1:0] mag;

   always_comb begin
      va = {2'b00, s1_big};
      vb = {2'b00, s1_small};
      if (s1_big_sgn)   va = -va;
      if (s1_small_sgn) vb = -vb;
      sum = va + vb;
      mag = sum[SW] ? SW'(-sum) : sum[SW-1:0];
   end

   logic             s2_valid, s2_sgn;
   logic [EXP_W-1:0] s2_exp;
   logic [SW-1:0]    s2_mag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_sgn   <= 1'b0;
         s2_exp   <= '0;
         s2_mag   <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_sgn   <= sum[SW];
         s2_exp   <= s1_exp;
         s2_mag   <= mag;
      end
   end

   logic [CW-1:0]          lz, lsh;
   logic [FW-1:0]          norm;
   logic signed [EW-1:0]   e_norm, e_fin;
   logic                   g, r, s, rnd_up;
   logic [MAN_W:0]         man_rnd;
   logic [EXP_W+MAN_W:0]   res;
   logic [2:0]             flags;

   float_lzc #(.W(SW), .CW(CW)) u_lzc (
      .in_vec (s2_mag),
      .count  (lz)
   );

   always_comb begin
      lsh = lz - CW'(1);
      if (s2_mag[SW-1]) begin
         norm   = s2_mag[SW-1:1] | FW'(s2_mag[0]);
         e_norm = $signed(EW'(s2_exp)) + E_ONE;
      end else begin
         norm   = FW'(s2_mag << lsh);
         e_norm = $signed(EW'(s2_exp)) - $signed(EW'(lsh));
      end
      g       = norm[2];
      r       = norm[1];
      s       = norm[0];
      rnd_up  = g & (r | s | norm[3]);
      man_rnd = {1'b0, norm[FW-2:3]} + MW1'(rnd_up);
      e_fin   = e_norm + (man_rnd[MAN_W] ? E_ONE : E_ZERO);
      res     = '0;
      flags   = '0;
      // Hidden bit is clear only when the sum cancelled to exactly zero.
      if (norm[FW-1]) begin
         flags[FLAG_INEXACT] = g | r | s;
         if (e_fin >= E_OVF) begin
            res             = {s2_sgn, EXP_W'(2**EXP_W - 2), {MAN_W{1'b1}}};
            flags[FLAG_OVF] = 1'b1;
         end else if (e_fin < E_FLUSH) begin
            res               = {s2_sgn, PW'(0)};
            flags[FLAG_FLUSH] = 1'b1;
         end else begin
            res = {s2_sgn, e_fin[EXP_W-1:0], man_rnd[MAN_W-1:0]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_res   <= '0;
         out_flags <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_res   <= res;
            out_flags <= flags;
         end
      end
   end

endmodule

// File: tb/tb_full_st_add_pipe.sv
// Directed bench for full_st_add_pipe: exact-integer reference model, per-cycle
// result/handshake compare, stall and async-reset scenarios.
module tb_full_st_add_pipe;
   import full_st_add_pipe_pkg::*;

   localparam int unsigned EXP_W     = 8;
   localparam int unsigned MAN_W     = 23;
   localparam int unsigned FLUSH_EXP = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_sub, out_valid, out_ready;
   logic [31:0] in_a, in_b, out_res;
   logic [2:0]  out_flags;

   always #5 clk = ~clk;

   full_st_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FLUSH_EXP(FLUSH_EXP)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sub    (in_sub),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_flags (out_flags)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [34:0] want;
   } vec_t;

   vec_t        vecs[$];
   logic [34:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_sent   = 0;
   int          n_recv   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic signed [127:0] sval(input float_t f, input int sh);
      logic signed [127:0] v;
      v        = '0;
      v[23:0]  = {1'b1, f.man};
      v        = v << sh;
      return f.sgn ? -v : v;
   endfunction

   // Exact sum as a scaled integer, then round-to-nearest-even to 24 bits.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      float_t              fa, fb;
      logic signed [127:0] sm, m, q, rem, half;
      int                  ea, eb, emin, p, sh, e;
      logic                sgn, inx;
      logic [31:0]         res;
      logic [2:0]          flg;
      fa     = a;
      fb     = b;
      fb.sgn = fb.sgn ^ sub;
      ea     = int'(fa.exp);
      eb     = int'(fb.exp);
      if (ea == 0 && eb == 0) return '0;
      if (ea != 0 && eb != 0 && (ea - eb > 40 || eb - ea > 40)) begin
         res = (ea > eb) ? fa : fb;
         return {3'b001, res};
      end
      emin = (ea == 0) ? eb : (eb == 0) ? ea : ((ea < eb) ? ea : eb);
      sm   = '0;
      if (ea != 0) sm = sm + sval(fa, ea - emin);
      if (eb != 0) sm = sm + sval(fb, eb - emin);
      if (sm == 0) return '0;
      sgn = sm < 0;
      m   = sgn ? -sm : sm;
      p   = 0;
      for (int i = 0; i < 128; i++) if (m[i]) p = i;
      if (p <= 23) begin
         q   = m << (23 - p);
         e   = emin - (23 - p);
         inx = 1'b0;
      end else begin
         sh   = p - 23;
         q    = m >> sh;
         rem  = m - (q << sh);
         half = 128'sd1 << (sh - 1);
         inx  = rem != 0;
         if (rem > half || (rem == half && q[0])) q = q + 1;
         e = emin + sh;
         if (q[24]) begin
            q = q >> 1;
            e++;
         end
      end
      flg = {2'b00, inx};
      if (e >= 255) begin
         res    = {sgn, 8'hFE, 23'h7FFFFF};
         flg[2] = 1'b1;
      end else if (e < int'(FLUSH_EXP)) begin
         res    = {sgn, 31'h0};
         flg[1] = 1'b1;
      end else begin
         res = {sgn, e[7:0], q[22:0]};
      end
      return {flg, res};
   endfunction

   task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [2:0] f, input logic [31:0] r);
      vec_t v;
      v.a    = a;
      v.b    = b;
      v.sub  = sub;
      v.want = {f, r};
      vecs.push_back(v);
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
      int waited;
      waited   = 0;
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      exp_q.push_back(model(a, b, sub));
      n_sent++;
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 50) begin
         @(posedge clk);
         waited++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      #1;
   endtask

   initial begin
      logic        stalled;
      logic [34:0] held;
      logic [34:0] e;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            stalled = 1'b0;
         end else begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (stalled) begin
               check("stall_valid", 64'(out_valid), 64'd1);
               check("stall_hold", 64'({out_flags, out_res}), 64'(held));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL spurious_result: got 0x%0h, required no output", {out_flags, out_res});
               end else begin
                  e = exp_q.pop_front();
                  check("result", 64'({out_flags, out_res}), 64'(e));
                  n_recv++;
               end
            end
            stalled = out_valid && !out_ready;
            held    = {out_flags, out_res};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_sub    = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;

      add_vec(32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 32'h40000000);
      add_vec(32'h40400000, 32'h3F800000, 1'b1, 3'b000, 32'h40000000);
      add_vec(32'h3FC00000, 32'h3FC00000, 1'b1, 3'b000, 32'h00000000);
      add_vec(32'h3F800000, 32'h30800000, 1'b0, 3'b001, 32'h3F800000);
      add_vec(32'h3F800000, 32'h33800001, 1'b0, 3'b001, 32'h3F800001);
      add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b100, 32'h7F7FFFFF);
      add_vec(32'h05000000, 32'h85400000, 1'b0, 3'b010, 32'h80000000);
      add_vec(32'h3FC00000, 32'hBFC00000, 1'b0, 3'b000, 32'h00000000);
      add_vec(32'hBF800000, 32'hBF800000, 1'b1, 3'b000, 32'h00000000);
      add_vec(32'h40000000, 32'hC0400000, 1'b0, 3'b000, 32'hBF800000);
      add_vec(32'h00000000, 32'h3F800000, 1'b0, 3'b000, 32'h3F800000);
      add_vec(32'h3F800000, 32'h3F800001, 1'b1, 3'b000, 32'hB4000000);
      add_vec(32'h3F800000, 32'h33800000, 1'b0, 3'b001, 32'h3F800000);
      add_vec(32'h3F800001, 32'h33800000, 1'b0, 3'b001, 32'h3F800002);
      add_vec(32'h7F000000, 32'h7F000000, 1'b0, 3'b100, 32'h7F7FFFFF);
      add_vec(32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 3'b100, 32'hFF7FFFFF);
      add_vec(32'h04800000, 32'h00000000, 1'b0, 3'b010, 32'h00000000);
      add_vec(32'h05000000, 32'h00000000, 1'b0, 3'b000, 32'h05000000);

      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_res", 64'(out_res), 64'd0);
      check("rst_out_flags", 64'(out_flags), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      foreach (vecs[i]) check("model_pin", 64'(model(vecs[i].a, vecs[i].b, vecs[i].sub)), 64'(vecs[i].want));

      @(posedge clk);
      #1;
      send(vecs[0].a, vecs[0].b, vecs[0].sub);
      @(negedge clk);
      check("latency_c1", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("latency_c2", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("latency_c3", 64'(out_valid), 64'd1);
      check("latency_res", 64'({out_flags, out_res}), 64'(vecs[0].want));
      @(posedge clk);
      #1;
      drain();

      for (int i = 1; i < vecs.size(); i++) send(vecs[i].a, vecs[i].b, vecs[i].sub);
      drain();

      fork
         begin
            for (int i = 0; i < 8; i++) send(vecs[i + 3].a, vecs[i + 3].b, vecs[i + 3].sub);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("stream_count", 64'(n_recv), 64'(n_sent));

      for (int i = 0; i < 3; i++) send(vecs[i + 9].a, vecs[i + 9].b, vecs[i + 9].sub);
      #2;
      reset = 1'b0;
      #1;
      check("async_valid", 64'(out_valid), 64'd0);
      check("async_res", 64'(out_res), 64'd0);
      exp_q.delete();
      n_sent = n_recv;
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (6) @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);

      check("final_count", 64'(n_recv), 64'(n_sent));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
